// File: rtl/tetris_input_ctrl.sv
// Button front-end for the Tetris core: per-button sync, debounce, auto-repeat
// and tick alignment, so each collected press shows up for exactly one game step.

module tetris_input_lane #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 20000000,
  parameter int unsigned REPEAT_RATE     = 5000000,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic CLK,
  input  logic reset,
  input  logic raw,
  input  logic tick,
  output logic out,
  output logic held
);
  localparam int unsigned CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RPT_LAST = TW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {IDLE, HOLD, DELAY, RPT} rpt_state_t;

  logic [1:0]    sync_q;
  logic [CW-1:0] db_cnt;
  logic [TW-1:0] timer;
  rpt_state_t    state;
  logic          ev;
  logic          pend;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], raw};
  end

  // Level flips only after the synced input has disagreed for DEBOUNCE_CYCLES in a row.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      db_cnt <= '0;
      held   <= 1'b0;
    end else if (sync_q[1] != held) begin
      if (db_cnt == DB_LAST) begin
        held   <= ~held;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CW'(1);
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // IDLE is only ever re-entered with held low, so held high in IDLE is a fresh press.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
      ev    <= 1'b0;
    end else begin
      ev <= 1'b0;
      if (!held) begin
        state <= IDLE;
        timer <= '0;
      end else begin
        case (state)
          IDLE: begin
            ev    <= 1'b1;
            timer <= '0;
            state <= REPEAT_EN ? DELAY : HOLD;
          end
          HOLD: state <= HOLD;
          DELAY: begin
            if (timer == DLY_LAST) begin
              ev    <= 1'b1;
              timer <= '0;
              state <= RPT;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          RPT: begin
            if (timer == RPT_LAST) begin
              ev    <= 1'b1;
              timer <= '0;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Events between ticks collapse into pend; a same-cycle ev bypasses it.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      pend <= 1'b0;
      out  <= 1'b0;
    end else if (tick) begin
      out  <= pend | ev;
      pend <= 1'b0;
    end else begin
      pend <= pend | ev;
    end
  end
endmodule

module tetris_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 20000000,
  parameter int unsigned REPEAT_RATE     = 5000000,
  parameter logic [3:0]  REPEAT_MASK     = 4'b1101
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       left_raw,
  input  logic       right_raw,
  input  logic       change_raw,
  input  logic       down_raw,
  input  logic       tick,
  output logic       left,
  output logic       right,
  output logic       change,
  output logic       down,
  output logic [3:0] held
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0] raw_vec;
  logic [NUM_LANES-1:0] out_vec;

  // Lane index follows the held bit order {left, right, change, down}.
  assign raw_vec = {left_raw, right_raw, change_raw, down_raw};
  assign {left, right, change, down} = out_vec;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    tetris_input_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE),
      .REPEAT_EN       (REPEAT_MASK[g])
    ) u_lane (
      .CLK   (CLK),
      .reset (reset),
      .raw   (raw_vec[g]),
      .tick  (tick),
      .out   (out_vec[g]),
      .held  (held[g])
    );
  end
endmodule

// File: doc/tetris_input_ctrl.md
# tetris_input_ctrl

Front-end input stage for the 8x8-matrix Tetris game. It conditions the four raw push-buttons (left, right, change/rotate, down) with a synchronizer, debouncer and auto-repeat engine. It then presents clean, one-event-per-game-step control levels to the game core. The game core samples its buttons once per movement step and asserts `tick` at that instant; this block aligns its outputs to that strobe so that no press is lost or counted twice.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 250000 — consecutive stable CLK cycles required before the debounced level changes (5 ms at 50 MHz).
- `REPEAT_DELAY`, default 20000000 — CLK cycles from the initial press event to the first auto-repeat event (400 ms).
- `REPEAT_RATE`, default 5000000 — CLK cycles between subsequent auto-repeat events (100 ms).
- `REPEAT_MASK`, default 4'b1101 — per-button auto-repeat enable. Bit order {left, right, change, down}; change/rotate never repeats by default.

Ports:
- `CLK` in 1 — single system clock; all logic runs on it.
- `reset` in 1 — asynchronous, active-high reset.
- `left_raw, right_raw, change_raw, down_raw` in 1 each — raw button levels, active-high, asynchronous to CLK.
- `tick` in 1 — one-CLK strobe from the game core marking its sampling instant.
- `left, right, change, down` out 1 each — tick-aligned event levels. High for exactly one tick period per collected event.
- `held` out 4 — debounced button levels {left, right, change, down}, for hold-style use (e.g. soft drop).

## Operation
- Reset values (asynchronous): all outputs 0. Synchronizer flops 0, debounced levels 0, counters 0, pending flags 0, all FSMs IDLE. Reset asserted mid-press discards everything; after release, a still-held button must re-debounce from zero.
- Synchronizer: a 2-flop chain per button. Nothing downstream uses the raw inputs.
- Debouncer, per button:
  - Counter increments while sync output ≠ debounced level, and clears to 0 whenever they are equal.
  - When the counter reaches `DEBOUNCE_CYCLES-1` and the levels still differ, the debounced level toggles and the counter clears.
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`; it never wraps.
- Repeat FSM, per button. The states are IDLE, DELAY and REPEAT.
  - IDLE: on a debounced rising edge, emit `ev` for 1 cycle, clear the timer, and go to DELAY if the mask bit is 1; otherwise go to HOLD-IDLE, which is IDLE with `ev` suppressed until release.
  - DELAY: when the timer reaches `REPEAT_DELAY-1`, emit `ev`, clear the timer, and go to REPEAT.
  - REPEAT: when the timer reaches `REPEAT_RATE-1`, emit `ev` and clear the timer.
  - Any state: a debounced low returns the FSM to IDLE with the timer cleared and no `ev`. Release has priority over a same-cycle timer expiry.
  - The timer width covers `max(REPEAT_DELAY, REPEAT_RATE)`.
- Tick alignment, per button (1-bit pending flag `pend`):
  - When `tick` = 0: `pend <= pend | ev`, and the output holds its value.
  - When `tick` = 1: `out <= pend | ev` and `pend <= 0`. An `ev` arriving in the same cycle as `tick` goes straight to the output and is not carried forward.
  - Multiple events between two ticks collapse to one (saturating flag).
  - With no `tick`, events accumulate in `pend` indefinitely and the outputs stay frozen.
- Buttons are fully independent; simultaneous presses produce simultaneous outputs. The game core arbitrates among them.

## Timing
- Raw rising edge to `held` high: DEBOUNCE_CYCLES+2 CLK edges after the first edge that samples the raw input high.
- `held` high to initial `ev`: 1 cycle, since `ev` is registered. Raw-to-`ev` latency is therefore DEBOUNCE_CYCLES+3.
- Initial `ev` to first repeat: REPEAT_DELAY cycles. Each later repeat follows REPEAT_RATE cycles after the previous one.
- `ev` to output: visible on the edge that samples the next `tick`, i.e. the output changes one cycle after `tick` is high.
- Output width: exactly one tick period (from one `tick` to the next).
- Raw release to `held` low: DEBOUNCE_CYCLES+2 cycles. No event is generated on release.

## Test plan
Parameters for all tests: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, REPEAT_MASK=4'b1101. Cycles are counted from the first edge that samples the raw input high.

1. Glitch rejection: `left_raw` high for 3 cycles, then low → `held` stays 0, no `ev`, and `left` stays 0 through the next 5 ticks.
2. Clean press: `right_raw` high for 8 cycles, `tick` every 20 cycles → `held[2]` is 1 from cycle 6, `ev` occurs at cycle 7, and `right` = 1 for exactly one tick period after the next `tick`, then 0.
3. Auto-repeat: `left_raw` held 40 cycles, `tick` every cycle → `ev` at cycles 7, 17, 20, 23, 26, … while held; `change_raw` held 40 cycles → a single event only.
4. Collapse: `down_raw` held 60 cycles, `tick` at cycle 50 only → `down` = 1 for one period, and `pend` clears. A `tick` at cycle 52 with no new `ev` produces `down` = 0.
5. Same-cycle `tick` and `ev`: `tick` asserted at cycle 7 of a `right` press → `right` = 1 at cycle 8, and `pend` stays 0.
6. Reset mid-operation: assert `reset` at cycle 15 of a held `left` press, release at cycle 17, keep the button held → all outputs 0 immediately. `held[3]` rises again 6 cycles after release and the repeat sequence restarts.
